// File: rtl/i2c_arbiter_if.sv
// i2c_arbiter_if
//   Bundles the two requester ports (A, B) and the I2C master command/data
//   port that i2c_arbiter shares between them.
//   Modports:
//     slave  - the arbiter: takes requests/strobes/bytes from A and B and
//              master status; drives grants, gated ready/read data and the
//              muxed command stream toward the master.
//     master - the environment (requesters plus I2C master): the reverse
//              directions.
interface i2c_arbiter_if;
    // Requester A (time-set writer)
    logic       a_req;
    logic       a_gnt;
    logic       a_wr_addr;
    logic       a_rd_addr;
    logic [6:0] a_addr;
    logic [7:0] a_byte_read;
    logic       a_in_valid;
    logic [7:0] a_in_data;
    logic       a_in_ready;
    logic       a_out_valid;
    logic [7:0] a_out_data;
    // Requester B (periodic DS1307 reader)
    logic       b_req;
    logic       b_gnt;
    logic       b_wr_addr;
    logic       b_rd_addr;
    logic [6:0] b_addr;
    logic [7:0] b_byte_read;
    logic       b_in_valid;
    logic [7:0] b_in_data;
    logic       b_in_ready;
    logic       b_out_valid;
    logic [7:0] b_out_data;
    // I2C master side
    logic       m_wr_addr;
    logic       m_rd_addr;
    logic [6:0] m_addr;
    logic [7:0] m_byte_read;
    logic       m_in_valid;
    logic [7:0] m_in_data;
    logic       m_in_ready;
    logic       m_out_valid;
    logic [7:0] m_out_data;

    modport slave (
        input  a_req, a_wr_addr, a_rd_addr, a_addr, a_byte_read, a_in_valid, a_in_data,
        output a_gnt, a_in_ready, a_out_valid, a_out_data,
        input  b_req, b_wr_addr, b_rd_addr, b_addr, b_byte_read, b_in_valid, b_in_data,
        output b_gnt, b_in_ready, b_out_valid, b_out_data,
        output m_wr_addr, m_rd_addr, m_addr, m_byte_read, m_in_valid, m_in_data,
        input  m_in_ready, m_out_valid, m_out_data
    );

    modport master (
        output a_req, a_wr_addr, a_rd_addr, a_addr, a_byte_read, a_in_valid, a_in_data,
        input  a_gnt, a_in_ready, a_out_valid, a_out_data,
        output b_req, b_wr_addr, b_rd_addr, b_addr, b_byte_read, b_in_valid, b_in_data,
        input  b_gnt, b_in_ready, b_out_valid, b_out_data,
        input  m_wr_addr, m_rd_addr, m_addr, m_byte_read, m_in_valid, m_in_data,
        output m_in_ready, m_out_valid, m_out_data
    );
endinterface

// File: rtl/i2c_arbiter.sv
// i2c_arbiter
//   Shares one I2C master command/data port between requester A (time-set
//   writer) and requester B (periodic DS1307 reader). One owner per
//   transaction; the owner's strobes and bytes are muxed to the master, read
//   bytes and ready go only to the owner, and the master must show
//   GUARD_CYCLES consecutive ready cycles after a release before any new
//   grant. Simultaneous requests alternate (round-robin on last owner);
//   PRIORITY_A picks who wins the very first tie.
//   Ports:
//     clk          system clock
//     reset_n      asynchronous reset, active-low
//     bus          i2c_arbiter_if.slave - requester A/B ports and master port
//     timeout_flag sticky forced-release indicator
//   Optional feature macro: ARB_TIMEOUT_EN - limits one grant to
//   TIMEOUT_CYCLES cycles; without it timeout_flag is tied low.
module i2c_arbiter #(
    parameter int unsigned PRIORITY_A     = 1,
    parameter int unsigned GUARD_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 131071
) (
    input  logic         clk,
    input  logic         reset_n,
    i2c_arbiter_if.slave bus,
    output logic         timeout_flag
);

    if (GUARD_CYCLES < 1 || GUARD_CYCLES > 15) begin : g_bad_guard
        $error("GUARD_CYCLES must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 131071) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..131071");
    end

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, DRAIN} state_t;

    localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

    state_t     state;
    logic       a_gnt_q;
    logic       b_gnt_q;
    logic       last_b;      // 1: B owned the bus most recently
    logic [3:0] guard_cnt;
    logic       a_ok;
    logic       b_ok;
    logic       pick_a;

`ifdef ARB_TIMEOUT_EN
    localparam logic [16:0] HOLD_LAST = 17'(TIMEOUT_CYCLES - 1);

    logic [16:0] hold_cnt;
    logic        a_blocked;  // forced off; must drop req before re-grant
    logic        b_blocked;
    logic        flag_q;
    logic        flag_b;     // requester whose grant was forced off

    assign a_ok         = bus.a_req & ~a_blocked;
    assign b_ok         = bus.b_req & ~b_blocked;
    assign timeout_flag = flag_q;
`else
    assign a_ok         = bus.a_req;
    assign b_ok         = bus.b_req;
    assign timeout_flag = 1'b0;
`endif

    assign pick_a    = a_ok & (~b_ok | last_b);
    assign bus.a_gnt = a_gnt_q;
    assign bus.b_gnt = b_gnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            a_gnt_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
            last_b    <= (PRIORITY_A == 1);
            guard_cnt <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            a_blocked <= 1'b0;
            b_blocked <= 1'b0;
            flag_q    <= 1'b0;
            flag_b    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    guard_cnt <= '0;
                    if (bus.m_in_ready && (a_ok || b_ok)) begin
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
                        if (flag_b != pick_a) flag_q <= 1'b0;
`endif
                        if (pick_a) begin
                            state   <= GNT_A;
                            a_gnt_q <= 1'b1;
                            last_b  <= 1'b0;
                        end else begin
                            state   <= GNT_B;
                            b_gnt_q <= 1'b1;
                            last_b  <= 1'b1;
                        end
                    end
                end
                GNT_A, GNT_B: begin
                    if (!((state == GNT_A) ? bus.a_req : bus.b_req)) begin
                        state     <= DRAIN;
                        a_gnt_q   <= 1'b0;
                        b_gnt_q   <= 1'b0;
                        guard_cnt <= '0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (hold_cnt == HOLD_LAST) begin
                        state     <= DRAIN;
                        a_gnt_q   <= 1'b0;
                        b_gnt_q   <= 1'b0;
                        guard_cnt <= '0;
                        flag_q    <= 1'b1;
                        flag_b    <= (state == GNT_B);
                        if (state == GNT_A) a_blocked <= 1'b1;
                        else                b_blocked <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    // Only an unbroken run of ready cycles counts as drained.
                    if (!bus.m_in_ready)              guard_cnt <= '0;
                    else if (guard_cnt == GUARD_LAST) state     <= IDLE;
                    else                              guard_cnt <= guard_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
`ifdef ARB_TIMEOUT_EN
            if (!bus.a_req) a_blocked <= 1'b0;
            if (!bus.b_req) b_blocked <= 1'b0;
`endif
        end
    end

    // Mux follows the state register so an async reset zeroes it at once.
    always_comb begin
        bus.m_wr_addr   = 1'b0;
        bus.m_rd_addr   = 1'b0;
        bus.m_addr      = '0;
        bus.m_byte_read = '0;
        bus.m_in_valid  = 1'b0;
        bus.m_in_data   = '0;
        bus.a_in_ready  = 1'b0;
        bus.a_out_valid = 1'b0;
        bus.a_out_data  = '0;
        bus.b_in_ready  = 1'b0;
        bus.b_out_valid = 1'b0;
        bus.b_out_data  = '0;
        case (state)
            GNT_A: begin
                bus.m_wr_addr   = bus.a_wr_addr;
                bus.m_rd_addr   = bus.a_rd_addr;
                bus.m_addr      = bus.a_addr;
                bus.m_byte_read = bus.a_byte_read;
                bus.m_in_valid  = bus.a_in_valid;
                bus.m_in_data   = bus.a_in_data;
                bus.a_in_ready  = bus.m_in_ready;
                bus.a_out_valid = bus.m_out_valid;
                bus.a_out_data  = bus.m_out_data;
            end
            GNT_B: begin
                bus.m_wr_addr   = bus.b_wr_addr;
                bus.m_rd_addr   = bus.b_rd_addr;
                bus.m_addr      = bus.b_addr;
                bus.m_byte_read = bus.b_byte_read;
                bus.m_in_valid  = bus.b_in_valid;
                bus.m_in_data   = bus.b_in_data;
                bus.b_in_ready  = bus.m_in_ready;
                bus.b_out_valid = bus.m_out_valid;
                bus.b_out_data  = bus.m_out_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Testbench for i2c_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all outputs compared every cycle against a
// behavioural model of ownership, drain and (optionally) timeout rules.
module tb_i2c_arbiter;
    localparam int GUARD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 20;
    localparam bit TO_ON = 1'b1;
`else
    localparam int TO = 131071;
    localparam bit TO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic timeout_flag;

    i2c_arbiter_if bus();

    i2c_arbiter #(
        .PRIORITY_A(1),
        .GUARD_CYCLES(GUARD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // own: 0 nobody, 1 A, 2 B. After a release the bus is "draining" until
    // GUARD consecutive ready cycles have been seen.
    int own, last, quiet, hold, flag_of;
    bit draining, flag;
    bit blk_a, blk_b;

    task automatic model_reset();
        own = 0; last = 2; quiet = 0; hold = 0; flag_of = 0;
        draining = 0; flag = 0; blk_a = 0; blk_b = 0;
    endtask

    task automatic model_step();
        bit ra, rb, ea, eb;
        int pick;
        ra = bus.a_req;
        rb = bus.b_req;
        if (own != 0) begin
            if (!((own == 1) ? ra : rb)) begin
                own = 0; draining = 1; quiet = 0;
            end else if (TO_ON && hold + 1 == TO) begin
                if (own == 1) blk_a = 1; else blk_b = 1;
                flag = 1; flag_of = own; own = 0; draining = 1; quiet = 0;
            end else begin
                hold++;
            end
        end else if (draining) begin
            if (bus.m_in_ready) begin
                quiet++;
                if (quiet == GUARD) draining = 0;
            end else begin
                quiet = 0;
            end
        end else if (bus.m_in_ready) begin
            ea = ra && !blk_a;
            eb = rb && !blk_b;
            pick = (ea && eb) ? ((last == 1) ? 2 : 1) : ea ? 1 : eb ? 2 : 0;
            if (pick != 0) begin
                own = pick; last = pick; hold = 0;
                if (flag_of == pick) flag = 0;
            end
        end
        if (!ra) blk_a = 0;
        if (!rb) blk_b = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                chk("a_gnt", bus.a_gnt, own == 1);
                chk("b_gnt", bus.b_gnt, own == 2);
                chk("m_wr_addr", bus.m_wr_addr, (own == 1) ? bus.a_wr_addr : (own == 2) ? bus.b_wr_addr : 1'b0);
                chk("m_rd_addr", bus.m_rd_addr, (own == 1) ? bus.a_rd_addr : (own == 2) ? bus.b_rd_addr : 1'b0);
                chk("m_addr", bus.m_addr, (own == 1) ? bus.a_addr : (own == 2) ? bus.b_addr : 7'h0);
                chk("m_byte_read", bus.m_byte_read, (own == 1) ? bus.a_byte_read : (own == 2) ? bus.b_byte_read : 8'h0);
                chk("m_in_valid", bus.m_in_valid, (own == 1) ? bus.a_in_valid : (own == 2) ? bus.b_in_valid : 1'b0);
                chk("m_in_data", bus.m_in_data, (own == 1) ? bus.a_in_data : (own == 2) ? bus.b_in_data : 8'h0);
                chk("a_in_ready", bus.a_in_ready, (own == 1) ? bus.m_in_ready : 1'b0);
                chk("b_in_ready", bus.b_in_ready, (own == 2) ? bus.m_in_ready : 1'b0);
                chk("a_out_valid", bus.a_out_valid, (own == 1) ? bus.m_out_valid : 1'b0);
                chk("b_out_valid", bus.b_out_valid, (own == 2) ? bus.m_out_valid : 1'b0);
                chk("a_out_data", bus.a_out_data, (own == 1) ? bus.m_out_data : 8'h0);
                chk("b_out_data", bus.b_out_data, (own == 2) ? bus.m_out_data : 8'h0);
                chk("timeout_flag", timeout_flag, flag);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.a_req = 0; bus.a_wr_addr = 0; bus.a_rd_addr = 0; bus.a_addr = '0;
        bus.a_byte_read = '0; bus.a_in_valid = 0; bus.a_in_data = '0;
        bus.b_req = 0; bus.b_wr_addr = 0; bus.b_rd_addr = 0; bus.b_addr = '0;
        bus.b_byte_read = '0; bus.b_in_valid = 0; bus.b_in_data = '0;
        bus.m_in_ready = 1; bus.m_out_valid = 0; bus.m_out_data = '0;
    endtask

    task automatic settle();
        clear_inputs();
        repeat (GUARD + 6) tick();
    endtask

    logic [7:0] rd_bytes [3];
    int n;
    int hi;

    initial begin
        rd_bytes[0] = 8'h30; rd_bytes[1] = 8'h59; rd_bytes[2] = 8'h12;
        clear_inputs();
        reset_n = 0;
        cmp_on = 1;

        // Reset holds everything off even with a request and strobe present.
        bus.a_req = 1;
        bus.a_wr_addr = 1;
        repeat (3) tick();
        chk("rst_a_gnt", bus.a_gnt, 0);
        chk("rst_m_wr_addr", bus.m_wr_addr, 0);
        bus.a_wr_addr = 0;
        reset_n = 1;
        tick();
        chk("rel_a_gnt", bus.a_gnt, 1);

        // Simultaneous requests straight after reset: A wins.
        reset_n = 0;
        bus.b_req = 1;
        tick();
        reset_n = 1;
        tick();
        chk("tie_a_gnt", bus.a_gnt, 1);
        chk("tie_b_gnt", bus.b_gnt, 0);

        // A releases: B must wait GUARD+2 cycles.
        bus.a_req = 0;
        n = 0;
        while (!bus.b_gnt && n < 50) begin
            tick();
            n++;
        end
        chk("handover_latency", n, GUARD + 2);

        // B owns: A's strobe is ignored, B's read reaches master and bytes.
        bus.a_wr_addr = 1; bus.a_addr = 7'h68;
        #1;
        chk("nonowner_m_wr", bus.m_wr_addr, 0);
        chk("nonowner_in_ready", bus.a_in_ready, 0);
        bus.b_rd_addr = 1; bus.b_addr = 7'h68; bus.b_byte_read = 8'd3;
        #1;
        chk("owner_m_rd", bus.m_rd_addr, 1);
        chk("owner_m_addr", bus.m_addr, 7'h68);
        chk("owner_byte_read", bus.m_byte_read, 3);
        tick();
        bus.a_wr_addr = 0; bus.b_rd_addr = 0;
        for (int i = 0; i < 3; i++) begin
            bus.m_out_valid = 1;
            bus.m_out_data = rd_bytes[i];
            #1;
            chk("rd_b_out_data", bus.b_out_data, rd_bytes[i]);
            chk("rd_a_out_data", bus.a_out_data, 0);
            chk("rd_a_out_valid", bus.a_out_valid, 0);
            tick();
            bus.m_out_valid = 0;
            tick();
        end

        // B releases while the master is busy for 10 cycles.
        bus.m_in_ready = 0;
        bus.b_req = 0;
        bus.a_req = 1;
        hi = 0;
        repeat (10) begin
            tick();
            if (bus.a_gnt) hi++;
        end
        chk("busy_no_grant", hi, 0);
        bus.m_in_ready = 1;
        n = 0;
        while (!bus.a_gnt && n < 50) begin
            tick();
            n++;
        end
        chk("busy_guard_latency", n, GUARD + 1);

        // Async reset in the middle of A's write.
        bus.a_in_valid = 1; bus.a_in_data = 8'hA5;
        #1;
        chk("pre_rst_m_in_valid", bus.m_in_valid, 1);
        reset_n = 0;
        #1;
        chk("async_m_in_valid", bus.m_in_valid, 0);
        chk("async_a_gnt", bus.a_gnt, 0);
        bus.a_in_valid = 0;
        tick();
        tick();
        reset_n = 1;
        settle();

        // Long hold by A while B waits.
        bus.a_req = 1;
        tick();
        chk("hold_a_gnt", bus.a_gnt, 1);
        bus.b_req = 1;
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.a_gnt) hi++;
            tick();
        end
        chk("hold_cycles", hi, (TO < 30) ? TO : 30);
        chk("hold_timeout_flag", timeout_flag, TO < 30);
        chk("hold_b_after", bus.b_gnt, TO < 30);
        settle();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            bus.a_req = bus.a_req ? ($urandom_range(0, 11) != 0) : ($urandom_range(0, 5) == 0);
            bus.b_req = bus.b_req ? ($urandom_range(0, 11) != 0) : ($urandom_range(0, 5) == 0);
            bus.m_in_ready = ($urandom_range(0, 7) != 0);
            bus.a_wr_addr = ($urandom_range(0, 3) == 0);
            bus.a_rd_addr = ($urandom_range(0, 3) == 0);
            bus.b_wr_addr = ($urandom_range(0, 3) == 0);
            bus.b_rd_addr = ($urandom_range(0, 3) == 0);
            bus.a_addr = 7'($urandom);
            bus.b_addr = 7'($urandom);
            bus.a_byte_read = 8'($urandom);
            bus.b_byte_read = 8'($urandom);
            bus.a_in_valid = 1'($urandom);
            bus.b_in_valid = 1'($urandom);
            bus.a_in_data = 8'($urandom);
            bus.b_in_data = 8'($urandom);
            bus.m_out_valid = 1'($urandom);
            bus.m_out_data = 8'($urandom);
            tick();
        end

        cmp_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
Name: i2c_arbiter

Overview:
- Shares the single I2C master command/data port between two requesters: A (time-set writer) and B (periodic DS1307 reader).
- Grants one requester per transaction and muxes its command strobes and byte stream to the master.
- Returns read bytes only to the owner and drains the master before any hand-over.
- Sits between the control logic / readback logic and the I2C master.

Parameters:
- PRIORITY_A, 1: 1 = A wins simultaneous requests when no history exists; round-robin applies after the first grant.
- GUARD_CYCLES, 4: cycles master in_ready must stay high after req release before grant may change (range 1..15).
- TIMEOUT_CYCLES, 131071: max cycles one owner may hold the grant (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- a_req, b_req  in  1  request; held high for the whole transaction, dropped to end it
- a_gnt, b_gnt  out  1  registered grant
- a_wr_addr, b_wr_addr  in  1  start-write strobe
- a_rd_addr, b_rd_addr  in  1  start-read strobe
- a_addr, b_addr  in  7  slave address
- a_byte_read, b_byte_read  in  8  read length
- a_in_valid, b_in_valid  in  1  write byte valid
- a_in_data, b_in_data  in  8  write byte
- a_in_ready, b_in_ready  out  1  master ready, gated by grant
- a_out_valid, b_out_valid  out  1  read byte valid, gated by grant
- a_out_data, b_out_data  out  8  read byte, zero when not granted
- m_wr_addr, m_rd_addr  out  1  to master
- m_addr  out  7  to master
- m_byte_read  out  8  to master
- m_in_valid  out  1  to master
- m_in_data  out  8  to master
- m_in_ready  in  1  master ready/idle
- m_out_valid  in  1  from master
- m_out_data  in  8  from master
- timeout_flag  out  1  sticky; set on forced release, cleared by the next grant to the same requester

Behaviour:
- Reset (reset_n low, async): state IDLE; a_gnt = b_gnt = 0; all m_* outputs 0; timeout_flag = 0; last_owner = B if PRIORITY_A = 1, else A. Returns to IDLE whenever reset is asserted mid-transaction.
- IDLE: all m_* = 0.
  - Only a_req high: next cycle GNT_A, a_gnt = 1.
  - Only b_req high: next cycle GNT_B, b_gnt = 1.
  - Both high: grant the requester that is not last_owner.
  - Grant issues only when m_in_ready = 1; otherwise stay in IDLE.
- GNT_x: m_* = combinational mux of x's inputs. x_in_ready = m_in_ready, x_out_valid = m_out_valid, x_out_data = m_out_data. The loser's in_ready, out_valid and out_data are 0. last_owner <= x on entry. Strobes from a non-owner are ignored, never latched or queued. x_req falling -> DRAIN; x_gnt drops on the same edge.
- DRAIN: m_* = 0; guard counter counts cycles with m_in_ready = 1 and reloads to 0 on any m_in_ready = 0. At GUARD_CYCLES -> IDLE.
  - A request arriving during DRAIN waits.
  - The old owner re-raising req during DRAIN is treated as a new request.
- Minimum latency:
  - req rise to gnt = 1 cycle.
  - req fall to other gnt = GUARD_CYCLES + 2 cycles.
- Grant is one-hot and never changes while m_in_ready = 0.

Optional Feature:
- ARB_TIMEOUT_EN defined: hold counter (17 bits) counts cycles in GNT_x. On reaching TIMEOUT_CYCLES, the arbiter forces DRAIN, drops x_gnt and sets timeout_flag. The owner must drop req before it is re-granted.
- ARB_TIMEOUT_EN undefined: no counter; timeout_flag is tied to 0; the grant is held indefinitely.

Test Plan:
- Reset: reset_n low with a_req = 1 -> a_gnt = 0, m_* = 0; release -> a_gnt = 1 one cycle later.
- Simultaneous a_req and b_req after reset (PRIORITY_A = 1) -> A granted. A drops req; B waits GUARD_CYCLES = 4 idle cycles, then b_gnt = 1.
- B granted: A pulses a_wr_addr with a_addr = 7'h68 -> m_wr_addr stays 0, a_in_ready = 0. B's rd_addr with b_byte_read = 3 reaches the master; three m_out_valid bytes 0x30, 0x59, 0x12 appear only on b_out_data.
- Owner drops req while m_in_ready = 0 for 10 cycles -> no grant change until 4 consecutive ready cycles.
- Reset asserted mid GNT_A with m_in_valid = 1 -> m_in_valid = 0 asynchronously, state IDLE.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 20: A holds req 30 cycles -> forced release at cycle 20, timeout_flag = 1, B granted after the guard; without the macro, A holds the grant for all 30 cycles.
